// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a built-in
// busy scoreboard. Decode reads operands and allocates destinations.
// Writeback commits results and clears the matching busy bits.
// Register 0 is hardwired to zero and is never busy.
// Optional feature: define REGFILE_MP_WRITE_BYPASS_EN to forward same-cycle
// write data straight to the read ports.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rs_id,
  output logic [NRD*XLEN-1:0]   rs_data,
  output logic [NRD-1:0]        rs_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0] rd_id,
  input  logic [NWR*XLEN-1:0]   rd_data,
  input  logic                  alloc_en,
  input  logic [$clog2(NREGS)-1:0] alloc_id,
  output logic [NREGS-1:0]      busy_vec
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs      [NREGS];
  logic [XLEN-1:0]  regs_next [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Next-state: later write ports overwrite earlier ones, and alloc is applied
  // last so a newly issued producer supersedes a same-cycle writeback.
  always_comb begin
    logic [AW-1:0] widx;
    widx      = '0;
    regs_next = regs;
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      widx = rd_id[j*AW +: AW];
      if (wr_en[j] && (widx != '0)) begin
        regs_next[widx] = rd_data[j*XLEN +: XLEN];
        busy_next[widx] = 1'b0;
      end
    end
    if (alloc_en && (alloc_id != '0)) begin
      busy_next[alloc_id] = 1'b1;
    end
    regs_next[0] = '0;
    busy_next[0] = 1'b0;
  end

  // State registers: asynchronous clear of every register and busy bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) begin
        regs[n] <= '0;
      end
      busy <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        regs[n] <= regs_next[n];
      end
      busy <= busy_next;
    end
  end

  // Combinational read ports; x0 and reset force zero data and not-busy.
  always_comb begin
    logic [AW-1:0]   ridx;
    logic [XLEN-1:0] d;
    logic            b;
`ifdef REGFILE_MP_WRITE_BYPASS_EN
    logic            fwd;
`endif
    rs_data = '0;
    rs_busy = '0;
    ridx    = '0;
    d       = '0;
    b       = 1'b0;
`ifdef REGFILE_MP_WRITE_BYPASS_EN
    fwd     = 1'b0;
`endif
    for (int i = 0; i < NRD; i++) begin
      ridx = rs_id[i*AW +: AW];
      d    = regs[ridx];
      b    = busy[ridx];
`ifdef REGFILE_MP_WRITE_BYPASS_EN
      fwd  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (rd_id[j*AW +: AW] == ridx)) begin
          d   = rd_data[j*XLEN +: XLEN];
          fwd = 1'b1;
        end
      end
      if (fwd) begin
        b = alloc_en && (alloc_id == ridx);
      end
`endif
      if (rst || (ridx == '0)) begin
        d = '0;
        b = 1'b0;
      end
      rs_data[i*XLEN +: XLEN] = d;
      rs_busy[i]              = b;
    end
  end

  // Scoreboard export; bit 0 is structurally never set.
  always_comb begin
    busy_vec = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp with 2 read and 2 write
// ports. Uses a table of directed vectors, hand-written sequences for reset
// and forwarding corners, and random traffic against an array-based model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    rs_id;
  logic [NRD*XLEN-1:0]  rs_data;
  logic [NRD-1:0]       rs_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    rd_id;
  logic [NWR*XLEN-1:0]  rd_data;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_id;
  logic [NREGS-1:0]     busy_vec;

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg  [32];
  logic        mbusy [32];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wid0;
    logic [4:0]  wid1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        ae;
    logic [4:0]  aid;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic [31:0] ebv;
  } vec_t;

  vec_t vecs [6];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_id    (rs_id),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .wr_en    (wr_en),
    .rd_id    (rd_id),
    .rd_data  (rd_data),
    .alloc_en (alloc_en),
    .alloc_id (alloc_id),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wid0, input logic [4:0] wid1,
                               input logic [31:0] wd0, input logic [31:0] wd1,
                               input logic ae, input logic [4:0] aid);
    wr_en    = we;
    rd_id    = {wid1, wid0};
    rd_data  = {wd1, wd0};
    alloc_en = ae;
    alloc_id = aid;
  endtask

  task automatic setReads(input logic [4:0] r0, input logic [4:0] r1);
    rs_id = {r1, r0};
  endtask

  task automatic modelReset();
    for (int n = 0; n < 32; n++) begin
      mreg[n]  = 32'h0;
      mbusy[n] = 1'b0;
    end
  endtask

  // Architectural update at a clock edge, from the rules in plain terms.
  task automatic modelUpdate();
    logic [4:0] id;
    if (rst) begin
      modelReset();
      return;
    end
    for (int j = 0; j < NWR; j++) begin
      id = rd_id[j*AW +: AW];
      if (wr_en[j] && id != 0) begin
        mreg[id]  = rd_data[j*XLEN +: XLEN];
        mbusy[id] = 1'b0;
      end
    end
    if (alloc_en && alloc_id != 0) mbusy[alloc_id] = 1'b1;
  endtask

  function automatic logic [31:0] mdlData(input int port);
    logic [4:0]  id;
    logic [31:0] d;
    id = rs_id[port*AW +: AW];
    if (rst || id == 0) return 32'h0;
    d = mreg[id];
`ifdef REGFILE_MP_WRITE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && rd_id[j*AW +: AW] == id) d = rd_data[j*XLEN +: XLEN];
`endif
    return d;
  endfunction

  function automatic logic mdlBusy(input int port);
    logic [4:0] id;
    logic       b;
    id = rs_id[port*AW +: AW];
    if (rst || id == 0) return 1'b0;
    b = mbusy[id];
`ifdef REGFILE_MP_WRITE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && rd_id[j*AW +: AW] == id) b = alloc_en && (alloc_id == id);
`endif
    return b;
  endfunction

  function automatic logic [31:0] mdlBusyVec();
    logic [31:0] v;
    for (int n = 0; n < 32; n++) v[n] = mbusy[n];
    return v;
  endfunction

  task automatic stepClock();
    @(posedge clk);
    modelUpdate();
    #1;
    wr_en    = '0;
    alloc_en = 1'b0;
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_data0"}, rs_data[31:0], mdlData(0));
    checkOutput({tag, "_data1"}, rs_data[63:32], mdlData(1));
    checkOutput({tag, "_busy0"}, {31'h0, rs_busy[0]}, {31'h0, mdlBusy(0)});
    checkOutput({tag, "_busy1"}, {31'h0, rs_busy[1]}, {31'h0, mdlBusy(1)});
    checkOutput({tag, "_busyvec"}, busy_vec, mdlBusyVec());
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    setReads(5'd1, 5'd2);
    modelReset();

    vecs[0] = '{2'b11, 5'd5, 5'd5, 32'h11111111, 32'h22222222, 1'b0, 5'd0,
                5'd5, 5'd0, 32'h22222222, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7,
                5'd7, 5'd5, 32'hAAAAAAAA, 32'h22222222, 1'b1, 1'b0, 32'h00000080};
    vecs[2] = '{2'b01, 5'd7, 5'd0, 32'h55555555, 32'h0, 1'b0, 5'd0,
                5'd7, 5'd7, 32'h55555555, 32'h55555555, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{2'b10, 5'd0, 5'd7, 32'h0, 32'h66666666, 1'b1, 5'd7,
                5'd7, 5'd5, 32'h66666666, 32'h22222222, 1'b1, 1'b0, 32'h00000080};
    vecs[4] = '{2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b1, 5'd0,
                5'd0, 5'd7, 32'h0, 32'h66666666, 1'b0, 1'b1, 32'h00000080};
    vecs[5] = '{2'b11, 5'd3, 5'd31, 32'hFFFFFFFF, 32'h12345678, 1'b0, 5'd0,
                5'd3, 5'd31, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 32'h00000080};

    // Outputs are forced to zero while reset is held.
    #2;
    checkOutput("rst_hold_data0", rs_data[31:0], 32'h0);
    checkOutput("rst_hold_data1", rs_data[63:32], 32'h0);
    checkOutput("rst_hold_busy", {30'h0, rs_busy}, 32'h0);
    checkOutput("rst_hold_busyvec", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Every index on every port reads zero and not-busy after reset.
    for (int idx = 0; idx < 32; idx++) begin
      setReads(5'(idx), 5'(31 - idx));
      #1;
      checkOutput($sformatf("reset_data0_x%0d", idx), rs_data[31:0], 32'h0);
      checkOutput($sformatf("reset_data1_x%0d", 31 - idx), rs_data[63:32], 32'h0);
      checkOutput($sformatf("reset_busy_x%0d", idx), {30'h0, rs_busy}, 32'h0);
    end
    checkOutput("reset_busyvec", busy_vec, 32'h0);

    // Fill x1..x31 through write port 0, checking before and after each edge.
    for (int c = 1; c < 32; c++) begin
      applyStimulus(2'b01, 5'(c), 5'd0, 32'hAAAAAAAA, 32'h0, 1'b0, 5'd0);
      setReads(5'(c), 5'(c - 1));
      #1;
`ifdef REGFILE_MP_WRITE_BYPASS_EN
      checkOutput($sformatf("fill_pre_x%0d", c), rs_data[31:0], 32'hAAAAAAAA);
`else
      checkOutput($sformatf("fill_pre_x%0d", c), rs_data[31:0], 32'h0);
`endif
      stepClock();
      #1;
      checkOutput($sformatf("fill_post_x%0d", c), rs_data[31:0], 32'hAAAAAAAA);
    end
    applyStimulus(2'b01, 5'd0, 5'd0, 32'hAAAAAAAA, 32'h0, 1'b0, 5'd0);
    setReads(5'd0, 5'd0);
    stepClock();
    #1;
    checkOutput("x0_after_write", rs_data[31:0], 32'h0);

    // Directed table: write/alloc interactions, read back after the edge.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].we, vecs[v].wid0, vecs[v].wid1, vecs[v].wd0, vecs[v].wd1,
                    vecs[v].ae, vecs[v].aid);
      stepClock();
      setReads(vecs[v].r0, vecs[v].r1);
      #1;
      checkOutput($sformatf("vec%0d_data0", v), rs_data[31:0], vecs[v].ed0);
      checkOutput($sformatf("vec%0d_data1", v), rs_data[63:32], vecs[v].ed1);
      checkOutput($sformatf("vec%0d_busy0", v), {31'h0, rs_busy[0]}, {31'h0, vecs[v].eb0});
      checkOutput($sformatf("vec%0d_busy1", v), {31'h0, rs_busy[1]}, {31'h0, vecs[v].eb1});
      checkOutput($sformatf("vec%0d_busyvec", v), busy_vec, vecs[v].ebv);
    end

    // Mid-cycle reset clears state immediately and drops the pending write.
    applyStimulus(2'b01, 5'd4, 5'd0, 32'h44444444, 32'h0, 1'b1, 5'd9);
    setReads(5'd3, 5'd4);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst_x3", rs_data[31:0], 32'h0);
    checkOutput("midrst_x4", rs_data[63:32], 32'h0);
    checkOutput("midrst_busyvec", busy_vec, 32'h0);
    stepClock();
    rst = 1'b0;
    #1;
    checkOutput("postrst_x3", rs_data[31:0], 32'h0);
    checkOutput("postrst_x4", rs_data[63:32], 32'h0);
    checkOutput("postrst_busyvec", busy_vec, 32'h0);

    // Same-cycle write and read of x9: forwarded only with the bypass build.
    applyStimulus(2'b01, 5'd9, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0);
    setReads(5'd0, 5'd9);
    #1;
`ifdef REGFILE_MP_WRITE_BYPASS_EN
    checkOutput("bypass_x9_pre", rs_data[63:32], 32'h12345678);
`else
    checkOutput("bypass_x9_pre", rs_data[63:32], 32'h0);
`endif
    stepClock();
    #1;
    checkOutput("bypass_x9_post", rs_data[63:32], 32'h12345678);

    // Random traffic against the model, checked before each edge.
    for (int it = 0; it < 400; it++) begin
      applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    $urandom, $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      setReads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      checkAgainstModel($sformatf("rand%0d", it));
      stepClock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
